// File: rtl/bullet_pool.sv
// Player projectile pool: fire-edge slot allocation, per-tick upward motion, pixel hit test, enemy-hit pulses.
// Latency: fired/hit pulses and slot state update one clock after the causing inputs; b_on/pix_on are combinational.
// No backpressure: a fire edge with no free slot is dropped; optional shot cooldown under BULLET_COOLDOWN_EN.
module bullet_pool #(
    parameter int N_BULLETS = 5,
    parameter int N_WAVE    = 5,
    parameter int P_W       = 16,
    parameter int B_W       = 2,
    parameter int B_H       = 6,
    parameter int SPEED     = 4,
    parameter int TOP_BOUND = 35,
    parameter int COOLDOWN  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 move_tick,
    input  logic                 pause,
    input  logic                 clear,
    input  logic                 fire,
    input  logic [9:0]           p_x,
    input  logic [9:0]           p_y,
    input  logic [9:0]           x,
    input  logic [9:0]           y,
    input  logic [N_WAVE-1:0]    e_w_on,
    input  logic [N_WAVE-1:0]    e_w_active,
    input  logic                 e_r_on,
    input  logic                 e_r_active,
    output logic [N_BULLETS-1:0] b_active,
    output logic [N_BULLETS-1:0] b_on,
    output logic                 pix_on,
    output logic                 fired,
    output logic [N_WAVE-1:0]    hit_w_enemy,
    output logic                 hit_r_enemy
);

    if (N_BULLETS < 1 || N_BULLETS > 8 || COOLDOWN < 0 || COOLDOWN > 255) begin : g_param_check
        $error("bullet_pool: N_BULLETS must be 1..8 and COOLDOWN 0..255");
    end

    localparam logic [9:0]  X_OFF  = 10'(P_W / 2 - B_W / 2);
    localparam logic [9:0]  Y_OFF  = 10'(B_H);
    localparam logic [9:0]  STEP   = 10'(SPEED);
    localparam logic [9:0]  MIN_Y  = 10'(TOP_BOUND + SPEED);
    localparam logic [10:0] W_EXT  = 11'(B_W);
    localparam logic [10:0] H_EXT  = 11'(B_H);

    logic [9:0]           bx    [N_BULLETS];
    logic [9:0]           by    [N_BULLETS];
    logic [9:0]           bx_nx [N_BULLETS];
    logic [9:0]           by_nx [N_BULLETS];
    logic [N_BULLETS-1:0] active_nx;
    logic [N_BULLETS-1:0] alloc_oh;
    logic [N_BULLETS-1:0] slot_hit;
    logic [N_WAVE-1:0]    w_hit_vec;
    logic                 r_hit_now;
    logic                 any_enemy;
    logic                 fire_q;
    logic                 fire_ok;
    logic                 cd_ok;
    logic                 found;

    // Pixel-inside test uses 11-bit sums so a bullet near x/y=1023 never wraps.
    always_comb begin
        b_on = '0;
        for (int i = 0; i < N_BULLETS; i++) begin
            b_on[i] = b_active[i]
                    && ({1'b0, x} >= {1'b0, bx[i]}) && ({1'b0, x} < ({1'b0, bx[i]} + W_EXT))
                    && ({1'b0, y} >= {1'b0, by[i]}) && ({1'b0, y} < ({1'b0, by[i]} + H_EXT));
        end
    end

    assign pix_on    = |b_on;
    assign w_hit_vec = e_w_on & e_w_active;
    assign r_hit_now = e_r_on & e_r_active;
    assign any_enemy = (|w_hit_vec) | r_hit_now;
    assign slot_hit  = b_on & {N_BULLETS{any_enemy}};

    always_comb begin
        alloc_oh = '0;
        found    = 1'b0;
        for (int i = 0; i < N_BULLETS; i++) begin
            if (!b_active[i] && !found) begin
                alloc_oh[i] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    assign fire_ok = fire & ~fire_q & ~pause & ~clear & found & cd_ok;

    always_comb begin
        active_nx = b_active;
        for (int i = 0; i < N_BULLETS; i++) begin
            bx_nx[i] = bx[i];
            by_nx[i] = by[i];
        end
        if (clear) begin
            active_nx = '0;
        end else if (!pause) begin
            for (int i = 0; i < N_BULLETS; i++) begin
                if (slot_hit[i]) begin
                    active_nx[i] = 1'b0;
                end else if (move_tick && b_active[i]) begin
                    // Compare before subtracting so by never wraps below zero.
                    if (by[i] >= MIN_Y) begin
                        by_nx[i] = by[i] - STEP;
                    end else begin
                        active_nx[i] = 1'b0;
                    end
                end
            end
            if (fire_ok) begin
                for (int i = 0; i < N_BULLETS; i++) begin
                    if (alloc_oh[i]) begin
                        active_nx[i] = 1'b1;
                        bx_nx[i]     = p_x + X_OFF;
                        by_nx[i]     = p_y - Y_OFF;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fire_q      <= 1'b0;
            b_active    <= '0;
            fired       <= 1'b0;
            hit_w_enemy <= '0;
            hit_r_enemy <= 1'b0;
            for (int i = 0; i < N_BULLETS; i++) begin
                bx[i] <= '0;
                by[i] <= '0;
            end
        end else begin
            fire_q      <= fire;
            b_active    <= active_nx;
            fired       <= fire_ok;
            hit_w_enemy <= (!clear && !pause && (|slot_hit)) ? w_hit_vec : '0;
            hit_r_enemy <= !clear && !pause && (|slot_hit) && r_hit_now;
            for (int i = 0; i < N_BULLETS; i++) begin
                bx[i] <= bx_nx[i];
                by[i] <= by_nx[i];
            end
        end
    end

`ifdef BULLET_COOLDOWN_EN
    logic [7:0] cd_cnt;

    assign cd_ok = (cd_cnt == 8'd0);

    // A new shot reloads the counter even if a move_tick lands on the same edge.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cd_cnt <= 8'd0;
        end else if (fire_ok) begin
            cd_cnt <= 8'(COOLDOWN);
        end else if (move_tick && !pause && cd_cnt != 8'd0) begin
            cd_cnt <= cd_cnt - 8'd1;
        end
    end
`else
    assign cd_ok = 1'b1;
`endif

endmodule

// File: tb/tb_bullet_pool.sv
// Scoreboard bench for bullet_pool: stimulus queues expected pulses/state, a negedge monitor compares.
module tb_bullet_pool;
    localparam int NB = 5;
    localparam int NW = 5;
    localparam logic [6:0] P_FIRED = 7'b1000000;
    localparam logic [6:0] P_HIT_R = 7'b0000001;
    localparam logic [6:0] P_HIT_W2 = 7'b0001000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          move_tick = 1'b0, pause = 1'b0, clear = 1'b0, fire = 1'b0;
    logic [9:0]    p_x = '0, p_y = '0, x = '0, y = '0;
    logic [NW-1:0] e_w_on = '0, e_w_active = '0;
    logic          e_r_on = 1'b0, e_r_active = 1'b0;
    logic [NB-1:0] b_active, b_on;
    logic          pix_on, fired, hit_r_enemy;
    logic [NW-1:0] hit_w_enemy;

    bullet_pool #(.N_BULLETS(NB), .N_WAVE(NW), .P_W(16), .B_W(2), .B_H(6),
                  .SPEED(4), .TOP_BOUND(35), .COOLDOWN(8)) dut (
        .clk(clk), .rst(rst), .move_tick(move_tick), .pause(pause), .clear(clear),
        .fire(fire), .p_x(p_x), .p_y(p_y), .x(x), .y(y),
        .e_w_on(e_w_on), .e_w_active(e_w_active), .e_r_on(e_r_on), .e_r_active(e_r_active),
        .b_active(b_active), .b_on(b_on), .pix_on(pix_on), .fired(fired),
        .hit_w_enemy(hit_w_enemy), .hit_r_enemy(hit_r_enemy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    string      pq_name[$];
    logic [6:0] pq_exp[$];
    int         pq_cyc[$];
    string      sq_name[$];
    int         sq_sel[$];
    logic [7:0] sq_exp[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse {fired, hit_w_enemy, hit_r_enemy} expected right after the next clock edge.
    task automatic exp_pulse(input string n, input logic [6:0] e);
        pq_name.push_back(n);
        pq_exp.push_back(e);
        pq_cyc.push_back(cyc + 1);
    endtask

    // sel 0: b_active, 1: b_on, 2: pix_on -- compared at the coming negedge.
    task automatic chk(input string n, input int sel, input logic [7:0] e);
        sq_name.push_back(n);
        sq_sel.push_back(sel);
        sq_exp.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        logic [6:0] pv;
        logic [6:0] pe;
        logic [7:0] act;
        logic [7:0] se;
        string      nm;
        int         sel;
        int         ec;
        pv = {fired, hit_w_enemy, hit_r_enemy};
        if (!rst && pv != 7'd0) begin
            n_cmp++;
            if (pq_exp.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_pulse cyc=%0d got=%b want=none", cyc, pv);
            end else begin
                nm = pq_name.pop_front();
                pe = pq_exp.pop_front();
                ec = pq_cyc.pop_front();
                if (pv !== pe || ec != cyc) begin
                    n_bad++;
                    $display("FAIL %s got=%b@%0d want=%b@%0d", nm, pv, cyc, pe, ec);
                end
            end
        end
        while (sq_exp.size() > 0) begin
            nm  = sq_name.pop_front();
            sel = sq_sel.pop_front();
            se  = sq_exp.pop_front();
            case (sel)
                0:       act = 8'(b_active);
                1:       act = 8'(b_on);
                default: act = {7'd0, pix_on};
            endcase
            n_cmp++;
            if (act !== se) begin
                n_bad++;
                $display("FAIL %s got=%b want=%b", nm, act, se);
            end
        end
    end

    initial begin
        repeat (2) tick();
        chk("rst_active", 0, 8'd0);
        tick();
        chk("rst_pix", 2, 8'd0);
        tick();
        rst = 1'b0;
        tick();

        // First shot: bx=436+8-1=443, by=487-6=481
        p_x = 10'd436; p_y = 10'd487;
        fire = 1'b1; exp_pulse("first_fire", P_FIRED);
        tick();
        fire = 1'b0;
        chk("spawn_active", 0, 8'b00001);
        x = 10'd443; y = 10'd481; chk("spawn_on_tl", 1, 8'b00001);
        tick();

`ifdef BULLET_COOLDOWN_EN
        move_tick = 1'b1;
        repeat (3) tick();
        move_tick = 1'b0;
        fire = 1'b1;
        tick();
        fire = 1'b0;
        chk("cd_blocked", 0, 8'b00001);
        move_tick = 1'b1;
        repeat (5) tick();
        move_tick = 1'b0;
        fire = 1'b1; exp_pulse("cd_expired_fire", P_FIRED);
        tick();
        fire = 1'b0;
        chk("cd_second", 0, 8'b00011);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("cd_clear", 0, 8'd0);
        tick();
`else
        x = 10'd444; y = 10'd486; chk("spawn_on_br", 1, 8'b00001);
        tick();
        x = 10'd445; chk("right_edge", 1, 8'd0);
        tick();
        x = 10'd444; y = 10'd487; chk("bottom_edge", 1, 8'd0);
        tick();
        y = 10'd480; chk("top_edge", 1, 8'd0);
        tick();

        // Slots 1..4 at bx = 127,147,167,187, by = 481
        for (int i = 1; i < NB; i++) begin
            p_x = 10'(100 + 20 * i);
            fire = 1'b1; exp_pulse("fill_fire", P_FIRED);
            tick();
            fire = 1'b0;
            tick();
        end
        chk("pool_full", 0, 8'b11111);
        fire = 1'b1;
        tick();
        fire = 1'b0;
        chk("sixth_dropped", 0, 8'b11111);
        tick();

        x = 10'd147; y = 10'd481; e_w_on = 5'b00100; e_w_active = 5'b11111;
        chk("slot2_on", 1, 8'b00100);
        exp_pulse("hit_w2", P_HIT_W2);
        tick();
        e_w_on = '0;
        chk("hit_w2_retire", 0, 8'b11011);
        tick();

        x = 10'd167; e_w_on = 5'b01000; e_w_active = 5'b10111;
        tick();
        e_w_on = '0; e_w_active = '0;
        chk("inactive_enemy", 0, 8'b11011);
        tick();

        x = 10'd127; e_r_on = 1'b1; e_r_active = 1'b1;
        exp_pulse("hit_r_slot1", P_HIT_R);
        tick();
        e_r_on = 1'b0;
        chk("hit_r_retire", 0, 8'b11001);
        tick();

        p_x = 10'd436;
        fire = 1'b1; exp_pulse("refill_slot1", P_FIRED);
        tick();
        fire = 1'b0;
        chk("refill_active", 0, 8'b11011);
        x = 10'd443; y = 10'd481;
        tick();
        chk("lowest_slot", 1, 8'b00011);
        fire = 1'b1; exp_pulse("refill_slot2", P_FIRED);
        tick();
        fire = 1'b0;
        chk("refill2_active", 0, 8'b11111);
        tick();

        // Fire edge in the same cycle slot 4 retires: pool is still full, edge dropped.
        fire = 1'b1; x = 10'd187; e_r_on = 1'b1;
        exp_pulse("hit_r_slot4", P_HIT_R);
        tick();
        fire = 1'b0; e_r_on = 1'b0;
        chk("retire_not_reused", 0, 8'b01111);
        tick();
        fire = 1'b1; exp_pulse("reuse_slot4", P_FIRED);
        tick();
        fire = 1'b0;
        chk("reuse_active", 0, 8'b11111);
        tick();

        clear = 1'b1; fire = 1'b1; x = 10'd443; e_w_on = 5'b00001; e_w_active = 5'b00001;
        tick();
        clear = 1'b0; fire = 1'b0; e_w_on = '0;
        chk("clear_all", 0, 8'd0);
        tick();

        fire = 1'b1; exp_pulse("motion_fire", P_FIRED);
        tick();
        fire = 1'b0;
        tick();
        pause = 1'b1; move_tick = 1'b1; fire = 1'b1; e_w_on = 5'b00001;
        repeat (3) tick();
        move_tick = 1'b0; e_w_on = '0;
        chk("pause_frozen", 1, 8'b00001);
        tick();
        pause = 1'b0;
        repeat (2) tick();
        chk("held_fire_no_shot", 0, 8'b00001);
        fire = 1'b0; e_w_active = '0;
        tick();

        move_tick = 1'b1;
        tick();
        move_tick = 1'b0;
        y = 10'd477; chk("moved_once", 1, 8'b00001);
        tick();
        y = 10'd483; chk("moved_bottom", 1, 8'd0);
        tick();
        move_tick = 1'b1;
        repeat (110) tick();
        move_tick = 1'b0;
        y = 10'd37; chk("at_top_row", 1, 8'b00001);
        tick();
        y = 10'd36; chk("above_top", 1, 8'd0);
        tick();
        move_tick = 1'b1;
        tick();
        move_tick = 1'b0;
        chk("retired_top", 0, 8'd0);
        y = 10'd1021;
        tick();
        chk("no_wrap", 2, 8'd0);
        tick();
`endif

        repeat (3) tick();
        while (pq_exp.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s got=none want=%b@%0d", pq_name.pop_front(), pq_exp.pop_front(),
                     pq_cyc.pop_front());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
